ui_uart_rx_frame: RTL
=====================

UI_UART_RX_FRAME -- requirements
Module: ui_uart_rx_frame

Interface
REQ-001 Parameter SYNC_BYTE, 8'hA5, frame start marker.
REQ-002 Parameter MAX_LEN, 8, maximum payload bytes per frame (1..8).
REQ-003 Parameter TIMEOUT_CLKS, 1_000_000, inter-byte timeout in clk cycles.
REQ-004 clk  in  1  system clock; single clock domain.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 rx_data  in  8  received byte; valid when rx_data_rdy=1.
REQ-007 rx_data_rdy  in  1  single-cycle byte strobe from the UART receiver.
REQ-008 frm_err  in  1  stop-bit error, qualified by rx_data_rdy.
REQ-009 cmd_valid  out  1  command frame available.
REQ-010 cmd_ready  in  1  consumer accepts the frame when cmd_valid&cmd_ready.
REQ-011 cmd_op  out  8  command byte.
REQ-012 cmd_len  out  4  payload length, 0..MAX_LEN.
REQ-013 cmd_data  out  64  payload; byte i at [8i+7:8i]; unused bytes 0.
REQ-014 err_chk, err_len, err_frm, err_tmo, err_ovf  out  1 each  single-cycle error pulses.

Function
REQ-015 Frame format SHALL be: SYNC_BYTE, CMD, LEN, LEN payload bytes, CHK, where CHK = XOR of CMD, LEN and all payload bytes.
REQ-016 FSM states SHALL be IDLE, CMD, LEN, DATA, CHK; a byte is consumed only in a cycle with rx_data_rdy=1.
REQ-017 IDLE: byte==SYNC_BYTE -> CMD; any other byte is discarded silently.
REQ-018 CMD: store byte as op, seed checksum -> LEN.
REQ-019 LEN: byte>MAX_LEN -> IDLE with err_len pulse; byte==0 -> CHK; otherwise -> DATA with byte index cleared.
REQ-020 DATA: store byte at the current index, increment index; last byte -> CHK; SYNC_BYTE in DATA is payload, with no resync.
REQ-021 CHK: mismatch -> IDLE with err_chk pulse; match -> IDLE and frame delivered per REQ-022.
REQ-022 Delivery: if cmd_valid==0 or cmd_ready==1 in the CHK cycle, the output registers SHALL load and cmd_valid=1 on the next cycle; otherwise the frame is dropped with an err_ovf pulse, and the held output is unchanged.
REQ-023 cmd_valid SHALL clear the cycle after cmd_valid&cmd_ready unless a new frame loads in that same cycle; outputs SHALL remain stable while cmd_valid&!cmd_ready.
REQ-024 A byte with frm_err=1 SHALL be discarded, pulse err_frm, and force IDLE from any state.
REQ-025 Timeout counter SHALL clear on every consumed byte and in IDLE; in any non-IDLE state, reaching TIMEOUT_CLKS-1 with no byte -> IDLE with err_tmo pulse.
REQ-026 If a byte arrives in the same cycle the timeout expires, the byte SHALL be processed and no timeout is taken.
REQ-027 Latency: cmd_valid SHALL rise exactly 1 clk after the rx_data_rdy of a correct CHK byte.
REQ-028 Error pulses SHALL last exactly 1 cycle and are mutually exclusive per byte.

Reset
REQ-029 With rst_n=0 at a clk edge: FSM=IDLE, cmd_valid=0, cmd_op=0, cmd_len=0, cmd_data=0, all err_*=0, counters and index 0.
REQ-030 Reset mid-frame SHALL discard the partial frame and any held output without pulsing any error.

Structure
REQ-031 Package ui_uart_pkg SHALL hold the FSM state enum and the default SYNC_BYTE and MAX_LEN constants.
REQ-032 No sub-module is required; the timeout counter, payload buffer and output register are inline.

Verification (TIMEOUT_CLKS=1000 on the bench)
REQ-033 Bytes A5 10 02 11 22 21, cmd_ready=1 -> cmd_valid for 1 cycle, op=8'h10, len=2, data=64'h2211.
REQ-034 Bytes A5 10 02 11 22 20 -> err_chk pulse, cmd_valid stays 0, next valid frame accepted.
REQ-035 Bytes A5 01 09 -> err_len pulse, FSM back to IDLE; bytes A5 01 00 01 -> op=8'h01, len=0, data=0.
REQ-036 Bytes A5 10 then 1000 idle clks -> err_tmo pulse; a byte arriving exactly on the expiring cycle is consumed with no err_tmo.
REQ-037 Two valid frames with cmd_ready=0 -> first is held stable, second gives err_ovf; raising cmd_ready returns the first frame only.
REQ-038 Byte 11 with frm_err=1 mid-DATA -> err_frm pulse, IDLE; rst_n=0 mid-frame -> all outputs 0 and no error pulse.

Source files
------------

// File: rtl/ui_uart_pkg.sv
// Shared definitions for the UART command-frame receiver: FSM state
// encoding and the default frame marker / payload limit.
package ui_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_LEN  = 3'd2,
        ST_DATA = 3'd3,
        ST_CHK  = 3'd4
    } rx_state_t;

    localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
    localparam int         DEF_MAX_LEN   = 8;

endpackage

// File: rtl/ui_uart_rx_frame.sv
// Frame parser sitting behind a UART byte receiver. It assembles
// SYNC, CMD, LEN, payload and XOR checksum into a command record,
// hands it to a valid/ready consumer, and reports framing, length,
// checksum, timeout and overflow problems as one-cycle pulses.
module ui_uart_rx_frame
    import ui_uart_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE    = DEF_SYNC_BYTE,
    parameter int         MAX_LEN      = DEF_MAX_LEN,
    parameter int         TIMEOUT_CLKS = 1_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_data_rdy,
    input  logic        frm_err,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [7:0]  cmd_op,
    output logic [3:0]  cmd_len,
    output logic [63:0] cmd_data,
    output logic        err_chk,
    output logic        err_len,
    output logic        err_frm,
    output logic        err_tmo,
    output logic        err_ovf
);

    // A counter of width 1 still works when the timeout is a single cycle.
    localparam int TW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);

    rx_state_t      state_q;
    logic [7:0]     op_q;
    logic [3:0]     len_q;
    logic [2:0]     idx_q;
    logic [7:0]     chk_q;
    logic [63:0]    pay_q;
    logic [TW-1:0]  tmo_cnt;

    logic byte_ok;
    logic tmo_hit;
    logic chk_match;
    logic load_out;
    logic last_data;

    // Decode of the current byte and of the delivery/timeout conditions.
    always_comb begin
        byte_ok   = rx_data_rdy && !frm_err;
        tmo_hit   = (state_q != ST_IDLE) && !rx_data_rdy && (tmo_cnt == TMO_LAST);
        chk_match = (rx_data == chk_q);
        load_out  = byte_ok && (state_q == ST_CHK) && chk_match && (!cmd_valid || cmd_ready);
        last_data = (({1'b0, idx_q} + 4'd1) == len_q);
    end

    // Frame FSM: walks the byte sequence, builds the payload and checksum,
    // and raises exactly one error pulse for any byte that breaks the frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            chk_q   <= '0;
            pay_q   <= '0;
            err_chk <= 1'b0;
            err_len <= 1'b0;
            err_frm <= 1'b0;
            err_tmo <= 1'b0;
            err_ovf <= 1'b0;
        end else begin
            err_chk <= 1'b0;
            err_len <= 1'b0;
            err_frm <= 1'b0;
            err_tmo <= 1'b0;
            err_ovf <= 1'b0;
            if (rx_data_rdy && frm_err) begin
                state_q <= ST_IDLE;
                err_frm <= 1'b1;
            end else if (rx_data_rdy) begin
                case (state_q)
                    ST_IDLE: begin
                        if (rx_data == SYNC_BYTE)
                            state_q <= ST_CMD;
                    end
                    ST_CMD: begin
                        op_q    <= rx_data;
                        chk_q   <= rx_data;
                        pay_q   <= '0;
                        state_q <= ST_LEN;
                    end
                    ST_LEN: begin
                        if (rx_data > 8'(MAX_LEN)) begin
                            state_q <= ST_IDLE;
                            err_len <= 1'b1;
                        end else begin
                            len_q   <= rx_data[3:0];
                            chk_q   <= chk_q ^ rx_data;
                            idx_q   <= '0;
                            state_q <= (rx_data == 8'd0) ? ST_CHK : ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        pay_q[{idx_q, 3'b000} +: 8] <= rx_data;
                        chk_q <= chk_q ^ rx_data;
                        idx_q <= idx_q + 3'd1;
                        if (last_data)
                            state_q <= ST_CHK;
                    end
                    ST_CHK: begin
                        state_q <= ST_IDLE;
                        if (!chk_match)
                            err_chk <= 1'b1;
                        else if (cmd_valid && !cmd_ready)
                            err_ovf <= 1'b1;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end else if (tmo_hit) begin
                state_q <= ST_IDLE;
                err_tmo <= 1'b1;
            end
        end
    end

    // Inter-byte timeout: restarts on every byte and whenever the parser idles.
    always_ff @(posedge clk) begin
        if (!rst_n || state_q == ST_IDLE || rx_data_rdy || tmo_hit)
            tmo_cnt <= '0;
        else
            tmo_cnt <= tmo_cnt + 1'b1;
    end

    // Output holding register: loads a checked frame when the slot is free
    // or being emptied this cycle, and stays frozen while the consumer stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd_valid <= 1'b0;
            cmd_op    <= '0;
            cmd_len   <= '0;
            cmd_data  <= '0;
        end else if (load_out) begin
            cmd_valid <= 1'b1;
            cmd_op    <= op_q;
            cmd_len   <= len_q;
            cmd_data  <= pay_q;
        end else if (cmd_valid && cmd_ready) begin
            cmd_valid <= 1'b0;
        end
    end

endmodule
